vector_line_stepper: RTL and testbench

Upstream sample generator for the vector display X/Y DAC path. Accepts one line segment per handshake, walks it point-by-point with integer Bresenham stepping, and presents 8-bit X and Y codes plus beam enable. The codes go straight into the per-axis DAC bit-remap stage. Blanked segments are beam-off repositioning moves with a settle wait.

---
 rtl/vector_display_pkg.sv | 31 +++
 rtl/vector_bresenham_core.sv | 94 +++++++++
 rtl/vector_line_stepper.sv | 147 ++++++++++++++
 tb/tb_vector_line_stepper.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_display_pkg.sv
// Shared types for the vector display sample path: FSM states, DAC width,
// segment descriptor and the signed Bresenham error type.
package vector_display_pkg;

   localparam int unsigned DAC_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      JUMP
   } state_t;

   typedef logic signed [9:0] err_t;

   typedef struct packed {
      logic [DAC_W-1:0] x0;
      logic [DAC_W-1:0] y0;
      logic [DAC_W-1:0] x1;
      logic [DAC_W-1:0] y1;
      logic             blank;
   } segment_t;

   // Absolute distance between two codes, widened into the error domain.
   function automatic err_t axis_span(input logic [DAC_W-1:0] a,
                                      input logic [DAC_W-1:0] b);
      logic [DAC_W-1:0] d;
      d = (b >= a) ? (b - a) : (a - b);
      return err_t'({2'b00, d});
   endfunction

endpackage

// File: rtl/vector_bresenham_core.sv
// Integer Bresenham walker: load a segment, then step one point per advance
// strobe; at_end flags that the current point is the segment end.
module vector_bresenham_core
   import vector_display_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             advance,
   input  logic [DAC_W-1:0] x0,
   input  logic [DAC_W-1:0] y0,
   input  logic [DAC_W-1:0] x1,
   input  logic [DAC_W-1:0] y1,
   output logic [DAC_W-1:0] x,
   output logic [DAC_W-1:0] y,
   output logic             at_end
);

   logic [DAC_W-1:0] x_q, x_d, y_q, y_d;
   logic [DAC_W-1:0] x1_q, x1_d, y1_q, y1_d;
   err_t             err_q, err_d, dx_q, dx_d, dy_q, dy_d;
   logic             sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

   logic signed [10:0] e2, dx_w, dy_w;
   err_t               err_n;

   assign x      = x_q;
   assign y      = y_q;
   assign at_end = (x_q == x1_q) && (y_q == y1_q);

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      err_d    = err_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;
      e2       = {err_q, 1'b0};
      dx_w     = {dx_q[9], dx_q};
      dy_w     = {dy_q[9], dy_q};
      err_n    = err_q;

      if (load) begin
         x_d      = x0;
         y_d      = y0;
         x1_d     = x1;
         y1_d     = y1;
         dx_d     = axis_span(x0, x1);
         dy_d     = -axis_span(y0, y1);
         err_d    = dx_d + dy_d;
         sx_neg_d = (x1 < x0);
         sy_neg_d = (y1 < y0);
      end else if (advance && !at_end) begin
         // Both axis decisions use the error value from before this step.
         if (e2 >= dy_w) begin
            err_n = err_n + dy_q;
            x_d   = sx_neg_q ? (x_q - DAC_W'(1)) : (x_q + DAC_W'(1));
         end
         if (e2 <= dx_w) begin
            err_n = err_n + dx_q;
            y_d   = sy_neg_q ? (y_q - DAC_W'(1)) : (y_q + DAC_W'(1));
         end
         err_d = err_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         err_q    <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         err_q    <= err_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
      end
   end

endmodule

// File: rtl/vector_line_stepper.sv
// Segment sequencer for the vector X/Y DAC path: drawn lines are walked point
// by point with a dwell per point, blanked moves jump and settle with beam off.
// Optional macro VECTOR_LINE_STEPPER_ENDPOINT_HOLD_EN extends the last drawn point.
module vector_line_stepper
   import vector_display_pkg::*;
#(
   parameter int unsigned DWELL         = 4,
   parameter int unsigned SETTLE        = 16,
   parameter int unsigned ENDPOINT_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seg_valid,
   output logic             seg_ready,
   input  logic [DAC_W-1:0] seg_x0,
   input  logic [DAC_W-1:0] seg_y0,
   input  logic [DAC_W-1:0] seg_x1,
   input  logic [DAC_W-1:0] seg_y1,
   input  logic             seg_blank,
   output logic [DAC_W-1:0] x_code,
   output logic [DAC_W-1:0] y_code,
   output logic             beam_on,
   output logic             busy,
   output logic             seg_done
);

`ifdef VECTOR_LINE_STEPPER_ENDPOINT_HOLD_EN
   localparam bit TAIL_EN = 1'b1;
`else
   localparam bit TAIL_EN = 1'b0;
`endif

   localparam int unsigned DRAW_MAX = DWELL + ENDPOINT_HOLD;
   localparam int unsigned HOLD_MAX = (DRAW_MAX > SETTLE) ? DRAW_MAX : SETTLE;
   localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tail_q, tail_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             beam_q, beam_d;
   logic             done_q, done_d;

   segment_t         seg_in;
   logic             accept;
   logic             core_load, core_adv, core_at_end;
   logic [DAC_W-1:0] start_x, start_y;

   assign seg_in    = {seg_x0, seg_y0, seg_x1, seg_y1, seg_blank};
   assign accept    = seg_valid && ready_q;
   // A blanked move is a zero-length walk starting at its destination.
   assign start_x   = seg_in.blank ? seg_in.x1 : seg_in.x0;
   assign start_y   = seg_in.blank ? seg_in.y1 : seg_in.y0;

   assign seg_ready = ready_q;
   assign busy      = busy_q;
   assign beam_on   = beam_q;
   assign seg_done  = done_q;

   vector_bresenham_core u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (core_load),
      .advance (core_adv),
      .x0      (start_x),
      .y0      (start_y),
      .x1      (seg_in.x1),
      .y1      (seg_in.y1),
      .x       (x_code),
      .y       (y_code),
      .at_end  (core_at_end)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tail_d    = tail_q;
      core_load = 1'b0;
      core_adv  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               core_load = 1'b1;
               tail_d    = 1'b0;
               if (seg_in.blank) begin
                  state_d = JUMP;
                  cnt_d   = CNT_W'(SETTLE - 1);
               end else begin
                  state_d = DRAW;
                  cnt_d   = CNT_W'(DWELL - 1);
               end
            end
         end
         DRAW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (core_at_end) begin
               if (TAIL_EN && !tail_q && (ENDPOINT_HOLD != 0)) begin
                  tail_d = 1'b1;
                  cnt_d  = CNT_W'(ENDPOINT_HOLD - 1);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               core_adv = 1'b1;
               cnt_d    = CNT_W'(DWELL - 1);
            end
         end
         JUMP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      beam_d  = (state_d == DRAW);
      done_d  = (state_q != IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tail_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         beam_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tail_q  <= tail_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         beam_q  <= beam_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_vector_line_stepper.sv
// Self-checking bench for vector_line_stepper against a cycle-level point-list model.
module tb_vector_line_stepper;

   localparam int DWELL  = 2;
   localparam int SETTLE = 16;
   localparam int EHOLD  = 8;
`ifdef VECTOR_LINE_STEPPER_ENDPOINT_HOLD_EN
   localparam int LAST_EXTRA = EHOLD;
`else
   localparam int LAST_EXTRA = 0;
`endif

   logic       clk, rst, seg_valid, seg_ready, seg_blank;
   logic [7:0] seg_x0, seg_y0, seg_x1, seg_y1, x_code, y_code;
   logic       beam_on, busy, seg_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x;
      int y;
      bit beam;
   } exp_t;
   exp_t exp_q[$];

   vector_line_stepper #(
      .DWELL         (DWELL),
      .SETTLE        (SETTLE),
      .ENDPOINT_HOLD (EHOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_valid (seg_valid),
      .seg_ready (seg_ready),
      .seg_x0    (seg_x0),
      .seg_y0    (seg_y0),
      .seg_x1    (seg_x1),
      .seg_y1    (seg_y1),
      .seg_blank (seg_blank),
      .x_code    (x_code),
      .y_code    (y_code),
      .beam_on   (beam_on),
      .busy      (busy),
      .seg_done  (seg_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation still running at 5ms, required completion");
      $fatal(1, "timeout");
   end

   // Cycle-by-cycle expected (x, y, beam) trace for one segment.
   function automatic void build_expect(int x0, int y0, int x1, int y1, bit blank);
      int x, y, dx, dy, sx, sy, err, e2, n;
      bit last;
      exp_q.delete();
      if (blank) begin
         for (int i = 0; i < SETTLE; i++) exp_q.push_back('{x1, y1, 1'b0});
         return;
      end
      dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      sx = (x1 >= x0) ? 1 : -1;
      sy = (y1 >= y0) ? 1 : -1;
      err = dx + dy;
      x = x0;
      y = y0;
      forever begin
         last = (x == x1) && (y == y1);
         n = DWELL + (last ? LAST_EXTRA : 0);
         for (int i = 0; i < n; i++) exp_q.push_back('{x, y, 1'b1});
         if (last) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   task automatic wait_ready(string tag);
      int n = 0;
      while (seg_ready !== 1'b1 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (seg_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready_wait: seg_ready=%b after %0d cycles, required 1", tag, seg_ready, n);
      end
   endtask

   // Offers a segment, follows it cycle by cycle, returns in the seg_done cycle.
   task automatic run_seg(string tag, int x0, int y0, int x1, int y1, bit blank, bit noise);
      int lx, ly;
      build_expect(x0, y0, x1, y1, blank);
      wait_ready(tag);
      seg_x0 = 8'(x0); seg_y0 = 8'(y0); seg_x1 = 8'(x1); seg_y1 = 8'(y1);
      seg_blank = blank;
      seg_valid = 1'b1;
      @(posedge clk); #1;
      seg_valid = 1'b0;
      foreach (exp_q[i]) begin
         if (noise && exp_q.size() > 3 && i == 1) begin
            seg_valid = 1'b1;
            seg_x0 = 8'($urandom); seg_y0 = 8'($urandom);
            seg_x1 = 8'($urandom); seg_y1 = 8'($urandom);
            seg_blank = 1'($urandom);
         end
         if (i == 2) seg_valid = 1'b0;
         checks++;
         if ({x_code, y_code, beam_on, busy, seg_done, seg_ready} !==
             {8'(exp_q[i].x), 8'(exp_q[i].y), exp_q[i].beam, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_cycle%0d: got x=%0d y=%0d beam=%b busy=%b done=%b rdy=%b, required x=%0d y=%0d beam=%b busy=1 done=0 rdy=0",
                     tag, i, x_code, y_code, beam_on, busy, seg_done, seg_ready,
                     exp_q[i].x, exp_q[i].y, exp_q[i].beam);
         end
         @(posedge clk); #1;
      end
      lx = exp_q[exp_q.size()-1].x;
      ly = exp_q[exp_q.size()-1].y;
      checks++;
      if ({x_code, y_code, beam_on, busy, seg_done, seg_ready} !==
          {8'(lx), 8'(ly), 1'b0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL %s_done: got x=%0d y=%0d beam=%b busy=%b done=%b rdy=%b, required x=%0d y=%0d beam=0 busy=0 done=1 rdy=1",
                  tag, x_code, y_code, beam_on, busy, seg_done, seg_ready, lx, ly);
      end
   endtask

   task automatic idle_gap(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         checks++;
         if (seg_done !== 1'b0 || busy !== 1'b0 || beam_on !== 1'b0) begin
            errors++;
            $display("FAIL idle_gap%0d: got done=%b busy=%b beam=%b, required 0 0 0", i, seg_done, busy, beam_on);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({x_code, y_code, beam_on, busy, seg_done, seg_ready} !== 20'h0) begin
         errors++;
         $display("FAIL reset_hold: got x=%0d y=%0d beam=%b busy=%b done=%b rdy=%b, required all 0",
                  x_code, y_code, beam_on, busy, seg_done, seg_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (seg_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready: got %b, required 0 before first edge", seg_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (seg_ready !== 1'b1 || busy !== 1'b0 || seg_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_cycle: got rdy=%b busy=%b done=%b, required 1 0 0", seg_ready, busy, seg_done);
      end
   endtask

   task automatic test_reset_mid();
      wait_ready("rstmid");
      seg_x0 = 8'd0; seg_y0 = 8'd0; seg_x1 = 8'd9; seg_y1 = 8'd0; seg_blank = 1'b0;
      seg_valid = 1'b1;
      @(posedge clk); #1;
      seg_valid = 1'b0;
      repeat (2 * DWELL) begin @(posedge clk); #1; end
      checks++;
      if (x_code !== 8'd2 || beam_on !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_point3: got x=%0d beam=%b, required x=2 beam=1", x_code, beam_on);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({x_code, y_code, beam_on, busy, seg_done, seg_ready} !== 20'h0) begin
         errors++;
         $display("FAIL rstmid_async: got x=%0d y=%0d beam=%b busy=%b done=%b rdy=%b, required all 0",
                  x_code, y_code, beam_on, busy, seg_done, seg_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (seg_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ready_low: got %b, required 0", seg_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (seg_ready !== 1'b1 || busy !== 1'b0 || seg_done !== 1'b0 || x_code !== 8'd0) begin
         errors++;
         $display("FAIL rstmid_after: got rdy=%b busy=%b done=%b x=%0d, required 1 0 0 0",
                  seg_ready, busy, seg_done, x_code);
      end
      idle_gap(3);
   endtask

   task automatic test_lines();
      run_seg("horiz", 0, 0, 3, 0, 1'b0, 1'b0);     idle_gap(2);
      run_seg("steep", 10, 10, 12, 15, 1'b0, 1'b0); idle_gap(1);
      run_seg("neg", 200, 50, 197, 47, 1'b0, 1'b0); idle_gap(1);
      run_seg("corner", 255, 255, 250, 255, 1'b0, 1'b0); idle_gap(1);
      run_seg("diag", 0, 255, 255, 0, 1'b0, 1'b0);  idle_gap(1);
      run_seg("degen", 77, 77, 77, 77, 1'b0, 1'b0); idle_gap(1);
   endtask

   task automatic test_blank();
      run_seg("blank", 13, 99, 255, 0, 1'b1, 1'b0);
      idle_gap(2);
   endtask

   task automatic test_back_to_back();
      run_seg("b2b_a", 5, 5, 8, 6, 1'b0, 1'b0);
      run_seg("b2b_b", 8, 6, 8, 2, 1'b0, 1'b1);
      run_seg("b2b_c", 0, 0, 40, 200, 1'b1, 1'b0);
      run_seg("b2b_d", 40, 200, 41, 200, 1'b0, 1'b0);
      idle_gap(1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         int x0, y0, x1, y1;
         bit short_seg;
         short_seg = ($urandom_range(0, 2) != 0);
         x0 = $urandom_range(0, 255);
         y0 = $urandom_range(0, 255);
         if (short_seg) begin
            x1 = x0 + $urandom_range(0, 20) - 10;
            y1 = y0 + $urandom_range(0, 20) - 10;
            x1 = (x1 < 0) ? 0 : (x1 > 255) ? 255 : x1;
            y1 = (y1 < 0) ? 0 : (y1 > 255) ? 255 : y1;
         end else begin
            x1 = $urandom_range(0, 255);
            y1 = $urandom_range(0, 255);
         end
         run_seg($sformatf("rand%0d", n), x0, y0, x1, y1,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
         idle_gap($urandom_range(0, 2));
      end
   endtask

   initial begin
      seg_valid = 1'b0;
      seg_blank = 1'b0;
      seg_x0 = '0; seg_y0 = '0; seg_x1 = '0; seg_y1 = '0;
      test_reset();
      test_lines();
      test_blank();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
